msio_datapath: RTL and testbench
================================

// Module: msio_datapath
// PURPOSE
//  Parametrised datapath for the simple-machine CPU: PC, IR, A, B, ALU, flags Z/N/C and external memory port.
//  Adds a registered I/O engine: in/out port accesses use valid/ready handshakes and stall the datapath via io_busy.
//  Driven cycle-by-cycle by the control unit, which consumes cop and the flags.
// PARAMETERS
//  DATA_W  16  word width of memory, IR, A, B, ALU and I/O data
//  ADDR_W  7   memory address width; PC width
//  PORT_W  5   I/O port number width; legal only if 2*ADDR_W <= DATA_W-2 and PORT_W <= DATA_W-4
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       asynchronous, active-high reset
//  mx_sel     in   2       address mux: 0=PC, 1=zero, 2=src field ir[2*ADDR_W-1:ADDR_W], 3=dst field ir[ADDR_W-1:0]
//  alu_op     in   3       ADD, SUB, AND, OR, XOR, PASS_A, PASS_B, SHL1 (codes 0..7)
//  le         in   1       memory write enable request
//  pc_w/ir_w/a_w/b_w in 1 each  register load enables
//  flags_w    in   1       load Z/N/C from ALU
//  mx_memio   in   1       memory write data: 0=ALU result, 1=io_buf
//  io_rd_req  in   1       start input transfer from port_addr
//  io_wr_req  in   1       start output transfer of mem_rdata to port_addr
//  cop        out  4       ir[DATA_W-1:DATA_W-4]
//  fz/fn/fc   out  1 each  zero, negative, carry flags
//  io_busy    out  1       high while I/O engine not IDLE
//  mem_addr   out  ADDR_W  mux output
//  mem_we     out  1       le & ~io_busy
//  mem_wdata  out  DATA_W  per mx_memio
//  mem_rdata  in   DATA_W  combinational read of mem_addr
//  port_addr  out  PORT_W  latched port number (field ir[DATA_W-5 -: PORT_W] at request)
//  in_data    in   DATA_W  input port data
//  in_valid   in   1       input data valid
//  in_ready   out  1       high in RD_WAIT
//  out_data   out  DATA_W  registered output data
//  out_valid  out  1       high in WR_WAIT
//  out_ready  in   1       output sink accepts
// BEHAVIOUR
//  Reset (async): pc, ir, a, b, io_buf, out_data, port_addr = 0; fz/fn/fc = 0; FSM IDLE; in_ready/out_valid = 0.
//  Reset mid-handshake aborts the transfer immediately; no partial data retained.
//  Registers update on posedge clk: pc <= mem_addr+1 (mod 2^ADDR_W, 127->0 wraps); ir/a/b <= mem_rdata.
//  Stall: while io_busy, pc_w, ir_w, a_w, b_w, flags_w and le are ignored (no state change, mem_we=0).
//  ALU: result DATA_W bits, combinational. ADD: fc=carry out. SUB: result A-B, fc=1 on borrow (A<B unsigned).
//   SHL1: fc=A[MSB]. Logic/PASS ops: fc=0. fz=(result==0), fn=result[MSB]. Flags load only on flags_w.
//  I/O FSM states IDLE, RD_WAIT, WR_WAIT:
//   IDLE: io_rd_req -> latch port field into port_addr, RD_WAIT. Else io_wr_req -> latch port_addr,
//    out_data <= mem_rdata, WR_WAIT. Both asserted: read wins, write dropped.
//   RD_WAIT: in_valid&in_ready -> io_buf <= in_data, IDLE. Otherwise hold.
//   WR_WAIT: out_valid&out_ready -> IDLE. out_data stable while out_valid.
//   Requests outside IDLE are ignored. Minimum transfer: request cycle + 1 handshake cycle;
//   io_busy falls the cycle after the handshake; control then writes io_buf with le=1, mx_memio=1.
//  No timeout; stall persists indefinitely until the peer handshakes or rst.
// STRUCTURE
//  msio_pkg: alu_op codes, mx_sel codes, io FSM state enum, field-position localparams derived from parameters.
//  Sub-module msio_alu (DATA_W): op, a, b -> result, z, n, c. FSM, registers and muxes stay in msio_datapath.
// TESTING (DATA_W=16, ADDR_W=7, PORT_W=5)
//  Reset: rst pulse during WR_WAIT -> out_valid=0, io_busy=0, pc=0 same cycle, fz/fn/fc=0.
//  PC wrap: pc=127, mx_sel=0, pc_w=1 -> pc=0; mx_sel=3, ir[6:0]=0x05 -> pc=0x06.
//  ALU: a=5, b=7, SUB, flags_w -> mem_wdata=0xFFFE, fz=0, fn=1, fc=1; ADD 0xFFFF+1 -> 0x0000, fz=1, fc=1.
//  Input: io_rd_req, port field 3, in_valid after 4 cycles with 0xBEEF -> port_addr=3, in_ready 4+ cycles,
//   io_busy drops 1 cycle after accept; le=1, mx_memio=1 -> mem_wdata=0xBEEF, mem_we=1.
//  Output: mem_rdata=0x1234, io_wr_req, out_ready low 3 cycles -> out_valid/out_data=0x1234 stable; pc_w, le ignored.
//  Collision: io_rd_req and io_wr_req same cycle -> RD_WAIT only, out_valid never asserts.

Source files
------------

// File: rtl/msio_pkg.sv
// ---------------------------------------------------------------------------
// msio_pkg
// Shared definitions for the simple-machine datapath and its I/O engine:
//   - ALU operation codes (alu_op_t)
//   - memory address mux selections (mx_sel_t)
//   - I/O engine states (io_state_t)
//   - fixed instruction-field geometry used to locate cop and the port field
// No ports; imported by msio_alu and msio_datapath.
// ---------------------------------------------------------------------------
package msio_pkg;

    typedef enum logic [2:0] {
        ALU_ADD    = 3'd0,
        ALU_SUB    = 3'd1,
        ALU_AND    = 3'd2,
        ALU_OR     = 3'd3,
        ALU_XOR    = 3'd4,
        ALU_PASS_A = 3'd5,
        ALU_PASS_B = 3'd6,
        ALU_SHL1   = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        MX_PC   = 2'd0,
        MX_ZERO = 2'd1,
        MX_SRC  = 2'd2,
        MX_DST  = 2'd3
    } mx_sel_t;

    typedef enum logic [1:0] {
        IO_IDLE    = 2'd0,
        IO_RD_WAIT = 2'd1,
        IO_WR_WAIT = 2'd2
    } io_state_t;

    // The opcode occupies the top COP_W bits of IR; the port-number field
    // starts immediately below it, so its MSB sits PORT_GAP bits under the
    // word MSB.
    localparam int COP_W    = 4;
    localparam int PORT_GAP = 4;

endpackage

// File: rtl/msio_alu.sv
// ---------------------------------------------------------------------------
// msio_alu
// Purely combinational ALU for the simple-machine datapath.
// Ports:
//   op     in  3       operation code (msio_pkg::alu_op_t encoding)
//   a, b   in  DATA_W  operands
//   result out DATA_W  operation result
//   z      out 1       result is zero
//   n      out 1       result MSB (negative)
//   c      out 1       carry (ADD), borrow (SUB), shifted-out bit (SHL1), else 0
// ---------------------------------------------------------------------------
module msio_alu
    import msio_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              z,
    output logic              n,
    output logic              c
);

    // SUB reports a borrow, i.e. c=1 exactly when A<B as unsigned numbers,
    // which is the inverse of the raw adder carry of A + ~B + 1.
    always_comb begin
        result = '0;
        c      = 1'b0;
        case (alu_op_t'(op))
            ALU_ADD:    {c, result} = {1'b0, a} + {1'b0, b};
            ALU_SUB: begin
                result = a - b;
                c      = (a < b);
            end
            ALU_AND:    result = a & b;
            ALU_OR:     result = a | b;
            ALU_XOR:    result = a ^ b;
            ALU_PASS_A: result = a;
            ALU_PASS_B: result = b;
            ALU_SHL1: begin
                result = {a[DATA_W-2:0], 1'b0};
                c      = a[DATA_W-1];
            end
            default: begin
                result = '0;
                c      = 1'b0;
            end
        endcase
    end

    assign z = (result == '0);
    assign n = result[DATA_W-1];

endmodule

// File: rtl/msio_datapath.sv
// ---------------------------------------------------------------------------
// msio_datapath
// Datapath of the simple-machine CPU: PC, IR, A, B, ALU, Z/N/C flags and the
// external memory port, plus a registered I/O engine that moves words between
// port_addr and the datapath with valid/ready handshakes. While the engine is
// busy every architectural write (registers, flags, memory) is suppressed.
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   mx_sel[2]                address mux: PC / zero / IR src / IR dst
//   alu_op[3]                ALU operation
//   le                       memory write request
//   pc_w, ir_w, a_w, b_w     register load enables
//   flags_w                  load Z/N/C from the ALU
//   mx_memio                 memory write data: 0=ALU, 1=io_buf
//   io_rd_req, io_wr_req     start input / output transfer
//   cop[4]                   opcode field of IR
//   fz, fn, fc               flags
//   io_busy                  I/O engine not idle
//   mem_addr, mem_we, mem_wdata, mem_rdata   memory port
//   port_addr[PORT_W]        port number latched at request
//   in_data, in_valid, in_ready              input handshake
//   out_data, out_valid, out_ready           output handshake
// ---------------------------------------------------------------------------
module msio_datapath
    import msio_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 7,
    parameter int PORT_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mx_sel,
    input  logic [2:0]        alu_op,
    input  logic              le,
    input  logic              pc_w,
    input  logic              ir_w,
    input  logic              a_w,
    input  logic              b_w,
    input  logic              flags_w,
    input  logic              mx_memio,
    input  logic              io_rd_req,
    input  logic              io_wr_req,
    output logic [COP_W-1:0]  cop,
    output logic              fz,
    output logic              fn,
    output logic              fc,
    output logic              io_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [PORT_W-1:0] port_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int SRC_MSB  = 2*ADDR_W - 1;
    localparam int SRC_LSB  = ADDR_W;
    localparam int DST_MSB  = ADDR_W - 1;
    localparam int PORT_MSB = DATA_W - 1 - PORT_GAP;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] reg_a;
    logic [DATA_W-1:0] reg_b;
    logic [DATA_W-1:0] io_buf;

    logic [DATA_W-1:0] alu_result;
    logic              alu_z;
    logic              alu_n;
    logic              alu_c;

    io_state_t state;
    io_state_t state_next;
    logic      start_rd;
    logic      start_wr;
    logic      rd_done;

    assign cop = ir[DATA_W-1 -: COP_W];

    // Address mux; the PC increment is taken from this mux so that jumps
    // through the IR fields land on (field + 1).
    always_comb begin
        mem_addr = pc;
        case (mx_sel_t'(mx_sel))
            MX_PC:   mem_addr = pc;
            MX_ZERO: mem_addr = '0;
            MX_SRC:  mem_addr = ir[SRC_MSB:SRC_LSB];
            MX_DST:  mem_addr = ir[DST_MSB:0];
            default: mem_addr = pc;
        endcase
    end

    msio_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op     (alu_op),
        .a      (reg_a),
        .b      (reg_b),
        .result (alu_result),
        .z      (alu_z),
        .n      (alu_n),
        .c      (alu_c)
    );

    assign mem_we    = le & ~io_busy;
    assign mem_wdata = mx_memio ? io_buf : alu_result;

    // Architectural registers and flags; all loads are frozen while the I/O
    // engine holds the datapath stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= '0;
            ir    <= '0;
            reg_a <= '0;
            reg_b <= '0;
            fz    <= 1'b0;
            fn    <= 1'b0;
            fc    <= 1'b0;
        end else if (!io_busy) begin
            if (pc_w) pc <= mem_addr + ADDR_ONE;
            if (ir_w) ir <= mem_rdata;
            if (a_w)  reg_a <= mem_rdata;
            if (b_w)  reg_b <= mem_rdata;
            if (flags_w) begin
                fz <= alu_z;
                fn <= alu_n;
                fc <= alu_c;
            end
        end
    end

    // I/O engine state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IO_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // I/O engine next state and handshake outputs. A read request wins over
    // a simultaneous write request; the write is simply dropped.
    always_comb begin
        state_next = state;
        start_rd   = 1'b0;
        start_wr   = 1'b0;
        rd_done    = 1'b0;
        io_busy    = 1'b1;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IO_IDLE: begin
                io_busy = 1'b0;
                if (io_rd_req) begin
                    start_rd   = 1'b1;
                    state_next = IO_RD_WAIT;
                end else if (io_wr_req) begin
                    start_wr   = 1'b1;
                    state_next = IO_WR_WAIT;
                end
            end
            IO_RD_WAIT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    rd_done    = 1'b1;
                    state_next = IO_IDLE;
                end
            end
            IO_WR_WAIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IO_IDLE;
                end
            end
            default: begin
                io_busy    = 1'b0;
                state_next = IO_IDLE;
            end
        endcase
    end

    // I/O data registers: port number and outgoing word are captured on the
    // request cycle, so out_data cannot move while out_valid is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            port_addr <= '0;
            out_data  <= '0;
            io_buf    <= '0;
        end else begin
            if (start_rd || start_wr) port_addr <= ir[PORT_MSB -: PORT_W];
            if (start_wr)             out_data  <= mem_rdata;
            if (rd_done)              io_buf    <= in_data;
        end
    end

endmodule

// File: tb/tb_msio_datapath.sv
// ---------------------------------------------------------------------------
// tb_msio_datapath
// Directed bench for msio_datapath (DATA_W=16, ADDR_W=7, PORT_W=5).
// Stimulus pushes expected observations into a queue; a monitor on the
// falling clock edge pops and compares them, and separately checks every
// output-port word against a queue of words the stimulus asked to send.
// ---------------------------------------------------------------------------
module tb_msio_datapath;
    import msio_pkg::*;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 7;
    localparam int PORT_W = 5;

    localparam int S_MEM_ADDR  = 0;
    localparam int S_MEM_WDATA = 1;
    localparam int S_MEM_WE    = 2;
    localparam int S_FZ        = 3;
    localparam int S_FN        = 4;
    localparam int S_FC        = 5;
    localparam int S_BUSY      = 6;
    localparam int S_IN_READY  = 7;
    localparam int S_OUT_VALID = 8;
    localparam int S_OUT_DATA  = 9;
    localparam int S_PORT_ADDR = 10;
    localparam int S_COP       = 11;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        mx_sel;
    logic [2:0]        alu_op;
    logic              le, pc_w, ir_w, a_w, b_w, flags_w, mx_memio;
    logic              io_rd_req, io_wr_req;
    logic [3:0]        cop;
    logic              fz, fn, fc, io_busy;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [PORT_W-1:0] port_addr;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    typedef struct {
        string       name;
        int          sig;
        logic [15:0] exp;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] out_q[$];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    msio_datapath #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .PORT_W (PORT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mx_sel    (mx_sel),
        .alu_op    (alu_op),
        .le        (le),
        .pc_w      (pc_w),
        .ir_w      (ir_w),
        .a_w       (a_w),
        .b_w       (b_w),
        .flags_w   (flags_w),
        .mx_memio  (mx_memio),
        .io_rd_req (io_rd_req),
        .io_wr_req (io_wr_req),
        .cop       (cop),
        .fz        (fz),
        .fn        (fn),
        .fc        (fc),
        .io_busy   (io_busy),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .port_addr (port_addr),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    function automatic logic [15:0] sample(input int sig);
        case (sig)
            S_MEM_ADDR:  return {9'b0, mem_addr};
            S_MEM_WDATA: return mem_wdata;
            S_MEM_WE:    return {15'b0, mem_we};
            S_FZ:        return {15'b0, fz};
            S_FN:        return {15'b0, fn};
            S_FC:        return {15'b0, fc};
            S_BUSY:      return {15'b0, io_busy};
            S_IN_READY:  return {15'b0, in_ready};
            S_OUT_VALID: return {15'b0, out_valid};
            S_OUT_DATA:  return out_data;
            S_PORT_ADDR: return {11'b0, port_addr};
            S_COP:       return {12'b0, cop};
            default:     return 16'hxxxx;
        endcase
    endfunction

    // Monitor: compares queued expectations, then scoreboards the output port.
    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [15:0] got;
        while (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            got = sample(e.sig);
            checks++;
            if (got !== e.exp) begin
                errors++;
                $display("[TB] FAIL %s: got 0x%04h expected 0x%04h", e.name, got, e.exp);
            end
        end
        if (out_valid === 1'b1) begin
            checks++;
            if (out_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL out_port: unexpected out_valid with out_data 0x%04h expected no transfer", out_data);
            end else begin
                if (out_data !== out_q[0]) begin
                    errors++;
                    $display("[TB] FAIL out_port: got 0x%04h expected 0x%04h", out_data, out_q[0]);
                end
                if (out_ready) void'(out_q.pop_front());
            end
        end
    end

    task automatic checkOutput(input string name, input int sig, input logic [15:0] exp);
        exp_q.push_back('{name, sig, exp});
    endtask

    task automatic applyStimulus(input logic [1:0] mx, input logic [2:0] op,
                                 input logic pcw, input logic irw, input logic aw,
                                 input logic bw, input logic fw, input logic lev,
                                 input logic memio, input logic rd, input logic wr,
                                 input logic [15:0] rdata);
        mx_sel    = mx;
        alu_op    = op;
        pc_w      = pcw;
        ir_w      = irw;
        a_w       = aw;
        b_w       = bw;
        flags_w   = fw;
        le        = lev;
        mx_memio  = memio;
        io_rd_req = rd;
        io_wr_req = wr;
        mem_rdata = rdata;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        applyStimulus(MX_PC, ALU_ADD, 0,0,0,0,0,0,0,0,0, 16'h0000);
        tick();
        checkOutput("rst mem_addr", S_MEM_ADDR, 16'h0000);
        checkOutput("rst fz", S_FZ, 0);
        checkOutput("rst fn", S_FN, 0);
        checkOutput("rst fc", S_FC, 0);
        checkOutput("rst io_busy", S_BUSY, 0);
        checkOutput("rst in_ready", S_IN_READY, 0);
        checkOutput("rst out_valid", S_OUT_VALID, 0);
        checkOutput("rst out_data", S_OUT_DATA, 16'h0000);
        checkOutput("rst port_addr", S_PORT_ADDR, 16'h0000);
        checkOutput("rst cop", S_COP, 16'h0000);
        tick();
        rst = 1'b0;
        tick();

        // Address mux and PC load/wrap
        applyStimulus(MX_PC, ALU_ADD, 0,1,0,0,0,0,0,0,0, 16'h1185);
        tick();
        applyStimulus(MX_DST, ALU_ADD, 1,0,0,0,0,0,0,0,0, 16'h0000);
        checkOutput("cop field", S_COP, 16'h0001);
        checkOutput("dst mux", S_MEM_ADDR, 16'h0005);
        tick();
        applyStimulus(MX_SRC, ALU_ADD, 0,0,0,0,0,0,0,0,0, 16'h0000);
        checkOutput("src mux", S_MEM_ADDR, 16'h0023);
        tick();
        applyStimulus(MX_PC, ALU_ADD, 0,1,0,0,0,0,0,0,0, 16'h007E);
        checkOutput("pc from dst+1", S_MEM_ADDR, 16'h0006);
        tick();
        applyStimulus(MX_DST, ALU_ADD, 1,0,0,0,0,0,0,0,0, 16'h0000);
        checkOutput("dst mux 0x7E", S_MEM_ADDR, 16'h007E);
        tick();
        applyStimulus(MX_PC, ALU_ADD, 1,0,0,0,0,0,0,0,0, 16'h0000);
        checkOutput("pc 127", S_MEM_ADDR, 16'h007F);
        tick();
        applyStimulus(MX_PC, ALU_ADD, 0,0,0,0,0,0,0,0,0, 16'h0000);
        checkOutput("pc wrap", S_MEM_ADDR, 16'h0000);
        tick();

        // ALU and flags
        applyStimulus(MX_PC, ALU_ADD, 0,0,1,0,0,0,0,0,0, 16'h0005);
        tick();
        applyStimulus(MX_PC, ALU_ADD, 0,0,0,1,0,0,0,0,0, 16'h0007);
        tick();
        applyStimulus(MX_PC, ALU_SUB, 0,0,0,0,1,0,0,0,0, 16'h0000);
        checkOutput("sub result", S_MEM_WDATA, 16'hFFFE);
        tick();
        applyStimulus(MX_PC, ALU_ADD, 0,0,1,0,0,0,0,0,0, 16'hFFFF);
        checkOutput("sub fz", S_FZ, 0);
        checkOutput("sub fn", S_FN, 1);
        checkOutput("sub fc", S_FC, 1);
        tick();
        applyStimulus(MX_PC, ALU_ADD, 0,0,0,1,0,0,0,0,0, 16'h0001);
        tick();
        applyStimulus(MX_PC, ALU_ADD, 0,0,0,0,1,0,0,0,0, 16'h0000);
        checkOutput("add wrap result", S_MEM_WDATA, 16'h0000);
        tick();
        applyStimulus(MX_PC, ALU_AND, 0,0,0,0,0,0,0,0,0, 16'h0000);
        checkOutput("add fz", S_FZ, 1);
        checkOutput("add fn", S_FN, 0);
        checkOutput("add fc", S_FC, 1);
        checkOutput("and result", S_MEM_WDATA, 16'h0001);
        tick();
        applyStimulus(MX_PC, ALU_SHL1, 0,0,0,0,1,0,0,0,0, 16'h0000);
        checkOutput("flags hold without flags_w", S_FZ, 1);
        checkOutput("shl1 result", S_MEM_WDATA, 16'hFFFE);
        tick();
        applyStimulus(MX_PC, ALU_ADD, 0,0,0,0,0,0,0,0,0, 16'h0000);
        checkOutput("shl1 fz", S_FZ, 0);
        checkOutput("shl1 fn", S_FN, 1);
        checkOutput("shl1 fc", S_FC, 1);
        tick();

        // Input transfer from port 3, peer answers after 4 waiting cycles
        applyStimulus(MX_PC, ALU_ADD, 0,1,0,0,0,0,0,0,0, 16'h0180);
        tick();
        applyStimulus(MX_PC, ALU_ADD, 0,0,0,0,0,0,0,1,0, 16'h0000);
        checkOutput("rd request cycle busy", S_BUSY, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(MX_PC, ALU_ADD, 0,0,1,0,1,1,0,0,0, 16'h5555);
            checkOutput("rd wait busy", S_BUSY, 1);
            checkOutput("rd wait in_ready", S_IN_READY, 1);
            checkOutput("rd wait mem_we", S_MEM_WE, 0);
            checkOutput("rd port_addr", S_PORT_ADDR, 16'h0003);
            tick();
        end
        applyStimulus(MX_PC, ALU_ADD, 0,0,0,0,0,0,0,0,0, 16'h0000);
        in_valid = 1'b1;
        in_data  = 16'hBEEF;
        checkOutput("rd accept in_ready", S_IN_READY, 1);
        tick();
        in_valid = 1'b0;
        applyStimulus(MX_PC, ALU_ADD, 0,0,0,0,0,1,1,0,0, 16'h0000);
        checkOutput("rd done busy", S_BUSY, 0);
        checkOutput("rd done in_ready", S_IN_READY, 0);
        checkOutput("io_buf to memory", S_MEM_WDATA, 16'hBEEF);
        checkOutput("io_buf mem_we", S_MEM_WE, 1);
        tick();
        applyStimulus(MX_PC, ALU_PASS_A, 0,0,0,0,0,0,0,0,0, 16'h0000);
        checkOutput("a held in stall", S_MEM_WDATA, 16'hFFFF);
        checkOutput("fz held in stall", S_FZ, 0);
        checkOutput("fn held in stall", S_FN, 1);
        tick();

        // Output transfer of 0x1234 to port 20, sink stalls 3 cycles
        applyStimulus(MX_PC, ALU_ADD, 0,1,0,0,0,0,0,0,0, 16'h0A00);
        tick();
        applyStimulus(MX_PC, ALU_ADD, 0,0,0,0,0,0,0,0,1, 16'h1234);
        out_q.push_back(16'h1234);
        checkOutput("wr request cycle busy", S_BUSY, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(MX_PC, ALU_ADD, 1,0,0,0,0,1,0,0,0, 16'hAAAA);
            checkOutput("wr wait busy", S_BUSY, 1);
            checkOutput("wr wait out_valid", S_OUT_VALID, 1);
            checkOutput("wr wait mem_we", S_MEM_WE, 0);
            checkOutput("wr port_addr", S_PORT_ADDR, 16'h0014);
            checkOutput("wr pc held", S_MEM_ADDR, 16'h0000);
            tick();
        end
        applyStimulus(MX_PC, ALU_ADD, 0,0,0,0,0,0,0,0,0, 16'hAAAA);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("wr done busy", S_BUSY, 0);
        checkOutput("wr done out_valid", S_OUT_VALID, 0);
        checkOutput("wr done pc", S_MEM_ADDR, 16'h0000);
        tick();

        // Read and write requested together: read wins
        applyStimulus(MX_PC, ALU_ADD, 0,0,0,0,0,0,0,1,1, 16'h7777);
        out_ready = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(MX_PC, ALU_ADD, 0,0,0,0,0,0,0,0,0, 16'h0000);
            checkOutput("collision in_ready", S_IN_READY, 1);
            checkOutput("collision out_valid", S_OUT_VALID, 0);
            checkOutput("collision busy", S_BUSY, 1);
            tick();
        end
        in_valid = 1'b1;
        in_data  = 16'h0042;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        applyStimulus(MX_PC, ALU_ADD, 0,0,0,0,0,0,1,0,0, 16'h0000);
        checkOutput("collision done busy", S_BUSY, 0);
        checkOutput("collision io_buf", S_MEM_WDATA, 16'h0042);
        checkOutput("collision port_addr", S_PORT_ADDR, 16'h0014);
        tick();

        // Reset in the middle of an output handshake
        applyStimulus(MX_PC, ALU_ADD, 1,0,0,0,0,0,0,0,0, 16'h0000);
        tick();
        applyStimulus(MX_PC, ALU_ADD, 0,0,0,0,0,0,0,0,1, 16'h5A5A);
        out_q.push_back(16'h5A5A);
        tick();
        applyStimulus(MX_PC, ALU_ADD, 0,0,0,0,0,0,0,0,0, 16'h0000);
        checkOutput("pre-reset out_valid", S_OUT_VALID, 1);
        checkOutput("pre-reset pc", S_MEM_ADDR, 16'h0001);
        tick();
        #2;
        rst = 1'b1;
        out_q.delete();
        checkOutput("async rst out_valid", S_OUT_VALID, 0);
        checkOutput("async rst busy", S_BUSY, 0);
        checkOutput("async rst pc", S_MEM_ADDR, 16'h0000);
        checkOutput("async rst fz", S_FZ, 0);
        checkOutput("async rst fn", S_FN, 0);
        checkOutput("async rst fc", S_FC, 0);
        checkOutput("async rst out_data", S_OUT_DATA, 16'h0000);
        checkOutput("async rst port_addr", S_PORT_ADDR, 16'h0000);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("post-reset busy", S_BUSY, 0);
        checkOutput("post-reset out_valid", S_OUT_VALID, 0);
        tick();
        tick();

        checks++;
        if (out_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL out_port drain: got %0d words pending expected 0", out_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
